// File: rtl/my_or.sv
// Bitwise OR element with a combinational result plus registered copy,
// sticky per-bit accumulator and saturating count of nonzero cycles.
module my_or #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8,
    localparam int ONES_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in1,
    input  logic [WIDTH-1:0]  in2,
    input  logic              clr,
    output logic [WIDTH-1:0]  out,
    output logic              any,
    output logic [ONES_W-1:0] ones,
    output logic [WIDTH-1:0]  out_q,
    output logic [WIDTH-1:0]  sticky,
    output logic [CNT_W-1:0]  hit_cnt
);

    function automatic logic [ONES_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [ONES_W-1:0] acc;
        acc = {ONES_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc + ONES_W'(v[i]);
        end
        return acc;
    endfunction

    // The combinational path is independent of clk/rst/clr so it works with the clock stopped.
    assign out  = in1 | in2;
    assign any  = |out;
    assign ones = popcount(out);

    // Shadow register, sticky accumulator and saturating hit counter; rst beats clr beats a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= {WIDTH{1'b0}};
            sticky  <= {WIDTH{1'b0}};
            hit_cnt <= {CNT_W{1'b0}};
        end else if (clr) begin
            out_q   <= out;
            sticky  <= {WIDTH{1'b0}};
            hit_cnt <= {CNT_W{1'b0}};
        end else begin
            out_q  <= out;
            sticky <= sticky | out;
            if (any && (hit_cnt != {CNT_W{1'b1}})) begin
                hit_cnt <= hit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                hit_cnt <= hit_cnt;
            end
        end
    end

endmodule

// File: tb/tb_my_or.sv
// Randomized self-checking bench for my_or against a rule-level reference model.
module tb_my_or;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst, clr;
    logic [7:0] in1, in2;
    logic [7:0] out, out_q, sticky;
    logic       any;
    logic [3:0] ones;
    logic [3:0] hit_cnt;

    logic       a1, b1, rst1, clr1;
    logic       out1, any1, ones1, out_q1, sticky1;
    logic [7:0] hit_cnt1;

    int tests = 0;
    int fails = 0;

    // reference model state
    int m_q, m_st, m_cnt;

    always #5 if (clk_en) clk = ~clk;

    my_or #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .clr(clr),
        .out(out), .any(any), .ones(ones), .out_q(out_q),
        .sticky(sticky), .hit_cnt(hit_cnt)
    );

    my_or u_dut1 (
        .clk(clk), .rst(rst1), .in1(a1), .in2(b1), .clr(clr1),
        .out(out1), .any(any1), .ones(ones1), .out_q(out_q1),
        .sticky(sticky1), .hit_cnt(hit_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check comb, apply the rules at posedge, check registers.
    task automatic cycle(input logic [7:0] a, input logic [7:0] b, input logic r, input logic c);
        int o, n;
        @(negedge clk);
        in1 = a; in2 = b; rst = r; clr = c;
        #1;
        o = 0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i] == 1'b1 || b[i] == 1'b1) begin
                o = o + (1 << i);
                n++;
            end
        end
        check("out", {24'd0, out}, o);
        check("any", {31'd0, any}, (n > 0) ? 1 : 0);
        check("ones", {28'd0, ones}, n);
        @(posedge clk);
        if (r) begin
            m_q = 0; m_st = 0; m_cnt = 0;
        end else if (c) begin
            m_q = o; m_st = 0; m_cnt = 0;
        end else begin
            m_q = o;
            m_st = m_st | o;
            if (o != 0 && m_cnt < 15) m_cnt++;
        end
        #1;
        check("out_q", {24'd0, out_q}, m_q);
        check("sticky", {24'd0, sticky}, m_st);
        check("hit_cnt", {28'd0, hit_cnt}, m_cnt);
    endtask

    initial begin
        logic [1:0] tt;
        logic [7:0] keep;
        rst = 1'b0; clr = 1'b0; in1 = 8'h00; in2 = 8'h00;
        rst1 = 1'b0; clr1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        m_q = 0; m_st = 0; m_cnt = 0;

        // Clock idle: WIDTH=1 truth table
        for (int i = 0; i < 4; i++) begin
            tt = 2'(i);
            a1 = tt[1]; b1 = tt[0];
            #10;
            check("tt_out1", {31'd0, out1}, (i == 0) ? 0 : 1);
            check("tt_any1", {31'd0, any1}, (i == 0) ? 0 : 1);
            check("tt_ones1", {31'd0, ones1}, (i == 0) ? 0 : 1);
        end
        in1 = 8'hA0; in2 = 8'h05;
        #10;
        check("a5_out", {24'd0, out}, 32'hA5);
        check("a5_ones", {28'd0, ones}, 4);
        check("a5_any", {31'd0, any}, 1);
        in1 = 8'h00; in2 = 8'h00;
        #10;
        check("zero_out", {24'd0, out}, 0);
        check("zero_any", {31'd0, any}, 0);
        check("zero_ones", {28'd0, ones}, 0);

        clk_en = 1'b1;
        rst1 = 1'b1;
        cycle(8'h3C, 8'h00, 1'b1, 1'b0);
        cycle(8'h3C, 8'h00, 1'b1, 1'b0);
        rst1 = 1'b0;

        // Directed: 01 then 80
        cycle(8'h01, 8'h00, 1'b0, 1'b0);
        check("q_01", {24'd0, out_q}, 32'h01);
        cycle(8'h00, 8'h80, 1'b0, 1'b0);
        check("q_80", {24'd0, out_q}, 32'h80);
        check("st_81", {24'd0, sticky}, 32'h81);
        check("cnt_2", {28'd0, hit_cnt}, 2);

        // Clear wins over a hit; rst wins over clr
        cycle(8'h12, 8'h40, 1'b0, 1'b1);
        check("clr_cnt", {28'd0, hit_cnt}, 0);
        check("clr_q", {24'd0, out_q}, 32'h52);
        cycle(8'h0F, 8'h00, 1'b1, 1'b1);
        check("rstclr_q", {24'd0, out_q}, 0);

        // Randomized traffic with occasional clears/resets
        for (int i = 0; i < 60; i++) begin
            cycle(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
        end

        // Saturation over 20 hit edges
        cycle(8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(8'h01 << (i % 8), 8'h00, 1'b0, 1'b0);
        check("sat_15", {28'd0, hit_cnt}, 15);

        // Reset mid-run
        cycle(8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(8'h22, 8'h04, 1'b0, 1'b0);
        check("mid_cnt5", {28'd0, hit_cnt}, 5);
        keep = out;
        cycle(8'h22, 8'h04, 1'b1, 1'b0);
        check("mid_out_kept", {24'd0, out}, {24'd0, keep});
        check("mid_rst_cnt", {28'd0, hit_cnt}, 0);
        check("mid_rst_st", {24'd0, sticky}, 0);
        cycle(8'h22, 8'h04, 1'b0, 1'b0);
        check("mid_resume", {28'd0, hit_cnt}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/my_or.md
# my_or

Bitwise OR primitive with a registered shadow path and sticky/event observability, used as the basic OR element in the gate-level library. The combinational output `out` is purely `in1 | in2`, with no dependence on clock or reset. The clocked side adds a registered copy, a sticky accumulator and a saturating count of cycles with a nonzero result, so the same block serves both glue logic and simple monitors.

## Interface
- `WIDTH`, default 1: bit width of `in1`, `in2`, `out`, `out_q`, `sticky`.
- `CNT_W`, default 8: width of `hit_cnt`.
- `clk`  input  1  rising-edge clock for all registered outputs.
- `rst`  input  1  reset; synchronous, active-high.
- `in1`  input  WIDTH  operand A.
- `in2`  input  WIDTH  operand B.
- `clr`  input  1  synchronous clear of `sticky` and `hit_cnt`.
- `out`  output  WIDTH  combinational `in1 | in2`.
- `any`  output  1  combinational reduction OR of `out`.
- `ones`  output  $clog2(WIDTH+1) (min 1)  combinational popcount of `out`.
- `out_q`  output  WIDTH  `out` registered on `clk`.
- `sticky`  output  WIDTH  per-bit OR of every sampled `out` since the last reset/clear.
- `hit_cnt`  output  CNT_W  count of sampled cycles with `any`=1; saturating.

## Operation
- `out[i] = in1[i] | in2[i]` for every bit i. Truth table per bit: 00→0, 01→1, 10→1, 11→1.
- `out`, `any` and `ones` are combinational only.
  - They are unaffected by `rst`, `clr` or `clk`.
  - They are valid with the clock stopped.
- Per rising edge, in priority order:
  - `rst`=1: `out_q`←0, `sticky`←0, `hit_cnt`←0.
  - else `clr`=1: `out_q`←`out`, `sticky`←0, `hit_cnt`←0. Clear wins over a same-cycle hit.
  - else: `out_q`←`out`, `sticky`←`sticky | out`, and `hit_cnt`←`hit_cnt`+1 if `any`=1 and `hit_cnt` is not all-ones. Otherwise `hit_cnt` holds.
- `hit_cnt` saturates at 2^CNT_W−1 and never wraps.
- X/Z on an input bit propagates per standard OR semantics: a 1 on either input dominates.

## Timing
- `out`, `any`, `ones` have zero-cycle latency: they settle within the same time step as an input change.
- `out_q` has 1-cycle latency: it reflects `out` sampled at the previous rising edge.
- `sticky` and `hit_cnt` include the current `out` from the edge at which it is sampled.
- Reset values: `out_q`=0, `sticky`=0, `hit_cnt`=0.
  - These are assigned only at a rising edge with `rst`=1.
  - Before the first such edge the registered outputs are undefined.
- Reset asserted mid-operation discards accumulated state at that edge. The combinational path continues uninterrupted.

## Test plan
- Combinational truth table, clock idle, WIDTH=1: apply (0,0),(0,1),(1,0),(1,1), 10 ns each → `out` = 0,1,1,1 after each 10 ns.
- WIDTH=8: `in1`=8'hA0, `in2`=8'h05 → `out`=8'hA5, `ones`=4, `any`=1. Then `in1`=`in2`=0 → `out`=0, `any`=0, `ones`=0.
- Registered path, reset:
  - Hold `rst`=1 for 2 edges → `out_q`=0, `sticky`=0, `hit_cnt`=0.
  - Release `rst`, drive `out`=8'h01 then 8'h80 on consecutive edges → `out_q` follows one edge late; `sticky`=8'h81; `hit_cnt`=2.
- Clear priority: `clr`=1 in a cycle with `any`=1 → after the edge `hit_cnt`=0 and `sticky`=0, while `out_q` still captures `out`. `rst`=1 together with `clr`=1 → `out_q`=0.
- Saturation, CNT_W=4: hold `any`=1 for 20 edges → `hit_cnt` reaches 15 and stays at 15.
- Reset mid-run: with `hit_cnt`=5 and `sticky`≠0, assert `rst` for one edge while inputs stay nonzero → registered outputs are 0 after that edge, `out` is unchanged throughout, and counting resumes at 1 on the next edge.
